// File: rtl/breath_defs.sv
// breath_defs: phase encodings and width defaults
// shared by the breathing-light sequencer and its bench.
package breath_defs;

  localparam int DUTY_W_DEF = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RISE    = 3'd1;
  localparam logic [2:0] ST_HOLD_HI = 3'd2;
  localparam logic [2:0] ST_FALL    = 3'd3;
  localparam logic [2:0] ST_HOLD_LO = 3'd4;

endpackage

// File: rtl/breath_sequencer_pwm_gen.sv
// pwm_gen: free-running PWM with a duty value that is
// only taken at period boundaries, registered output.
module pwm_gen
  import breath_defs::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] duty,
  output logic              light
);

  localparam logic [DUTY_W-1:0] CMAX = '1;

  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] duty_active;

  // period counter, boundary-aligned duty latch, compare
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt     <= '0;
      duty_active <= '0;
      light       <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + DUTY_W'(1);
      if (pwm_cnt == CMAX)
        duty_active <= duty;
      light <= (pwm_cnt < duty_active);
    end
  end

endmodule

// File: rtl/breath_sequencer.sv
// breath_sequencer: four-phase fade profile with
// prescaled step ticks, graceful fade-out and PWM drive.
module breath_sequencer
  import breath_defs::*;
#(
  parameter int PRESCALE   = 50000,
  parameter int HOLD_STEPS = 64,
  parameter int DUTY_W     = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        speed,
  input  logic              freeze,
  output logic              light,
  output logic [DUTY_W-1:0] duty,
  output logic [2:0]        phase,
  output logic              cycle_done
);

  localparam int PW = $clog2(PRESCALE * 8 + 1);
  localparam int HW =
    (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [DUTY_W-1:0] DMAX = '1;
  localparam logic [DUTY_W-1:0] DPRE =
    DMAX - DUTY_W'(1);
  localparam logic [HW-1:0] HLAST =
    HW'(HOLD_STEPS - 1);

  logic [PW-1:0] pcnt;
  logic [PW-1:0] plast;
  logic [HW-1:0] hold_cnt;
  logic          tick;

  // >= rather than == so a speed cut never waits for a wrap
  assign plast = (PW'(PRESCALE) << speed) - PW'(1);
  assign tick  = (phase != ST_IDLE) && !freeze &&
                 (pcnt >= plast);

  // step prescaler, idle-cleared, held while frozen
  always_ff @(posedge clk) begin
    if (rst || phase == ST_IDLE)
      pcnt <= '0;
    else if (tick)
      pcnt <= '0;
    else if (!freeze)
      pcnt <= pcnt + PW'(1);
  end

  // phase sequencing and duty profile
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= ST_IDLE;
      duty       <= '0;
      hold_cnt   <= '0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      unique case (phase)
        ST_IDLE: begin
          if (en)
            phase <= ST_RISE;
        end
        ST_RISE: begin
          if (!en)
            phase <= ST_FALL;
          else if (tick) begin
            duty <= duty + DUTY_W'(1);
            if (duty == DPRE) begin
              phase    <= ST_HOLD_HI;
              hold_cnt <= '0;
            end
          end
        end
        ST_HOLD_HI: begin
          if (!en)
            phase <= ST_FALL;
          else if (tick) begin
            if (hold_cnt == HLAST)
              phase <= ST_FALL;
            else
              hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_FALL: begin
          // <= 1 also covers a fade-out begun at duty 0
          if (tick) begin
            if (duty <= DUTY_W'(1)) begin
              duty     <= '0;
              hold_cnt <= '0;
              phase    <= en ? ST_HOLD_LO : ST_IDLE;
            end else
              duty <= duty - DUTY_W'(1);
          end
        end
        ST_HOLD_LO: begin
          if (!en)
            phase <= ST_IDLE;
          else if (tick) begin
            if (hold_cnt == HLAST) begin
              phase      <= ST_RISE;
              cycle_done <= 1'b1;
            end else
              hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          phase <= ST_IDLE;
          duty  <= '0;
        end
      endcase
    end
  end

  pwm_gen #(
    .DUTY_W(DUTY_W)
  ) u_pwm (
    .clk  (clk),
    .rst  (rst),
    .duty (duty),
    .light(light)
  );

endmodule

// File: doc/breath_sequencer.md
Name: breath_sequencer

Overview:
- Breathing-light controller for the board LED: owns the brightness (duty) profile and the PWM that drives `light`.
- Sequences a 4-phase fade cycle: RISE, HOLD_HI, FALL, HOLD_LO.
- Provides enable with graceful fade-out, speed select, freeze, and a per-cycle completion pulse.
- Instantiated by the top level in place of a free-running breathing generator; `light` goes straight to the LED pin.

Parameters:
- PRESCALE, 50000, clk cycles per duty step at speed=0 (must be ≥ 2).
- HOLD_STEPS, 64, steps spent in each HOLD phase (≥ 1).
- DUTY_W, 8, duty/PWM width; DUTY_MAX = 2^DUTY_W − 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  run request; level-sensitive.
- speed  in  2  step-period multiplier: step period = PRESCALE << speed.
- freeze  in  1  suspends step ticks (profile holds); PWM keeps running.
- light  out  1  PWM LED drive, registered.
- duty  out  DUTY_W  current target duty.
- phase  out  3  state: 0 IDLE, 1 RISE, 2 HOLD_HI, 3 FALL, 4 HOLD_LO.
- cycle_done  out  1  one-cycle pulse at HOLD_LO→RISE.

Behaviour:
- Reset:
  - Reset is synchronous, active-high, on clk; it overrides everything.
  - On any edge with rst=1: phase=IDLE, duty=0, duty_active=0, light=0, cycle_done=0, prescaler=0, hold_cnt=0, pwm_cnt=0.
  - Reset mid-operation takes effect at the next edge; there is no fade-out.
- Prescaler:
  - Counts while phase≠IDLE and freeze=0.
  - tick=1 on the cycle where count ≥ (PRESCALE<<speed)−1; the count returns to 0 on that cycle.
  - The ≥ comparison makes a speed decrease take effect immediately, with no long wrap.
  - While freeze=1 the count holds and no tick is generated.
  - Cleared on IDLE→RISE.
- FSM (transitions and duty updates are registered on the tick cycle):
  - IDLE: en=1 → RISE next edge; duty stays 0.
  - RISE: on tick, duty += 1. A tick with duty = DUTY_MAX−1 sets duty = DUTY_MAX, enters HOLD_HI and sets hold_cnt=0.
  - HOLD_HI: on tick, hold_cnt += 1. A tick with hold_cnt = HOLD_STEPS−1 → FALL.
  - FALL: on tick, duty −= 1. A tick with duty = 1 sets duty = 0, then:
    - en=1 → HOLD_LO with hold_cnt=0;
    - en=0 → IDLE.
  - HOLD_LO: on a tick with hold_cnt = HOLD_STEPS−1 → RISE, with cycle_done=1 for exactly that one cycle.
- en deassert (graceful fade-out):
  - In RISE or HOLD_HI: → FALL on the next edge, even without a tick; duty is unchanged on that edge.
  - In HOLD_LO: → IDLE next edge, with no cycle_done.
  - In FALL: continue fading down; IDLE at duty 0.
- en reasserted during the fade-out FALL: the sequencer stays in FALL and then follows the normal en=1 path.
- Arithmetic:
  - duty never wraps; saturation is guaranteed by the transitions above.
  - One full cycle = 2·DUTY_MAX + 2·HOLD_STEPS ticks.
- PWM:
  - pwm_cnt is a free-running DUTY_W-bit counter that wraps DUTY_MAX→0.
  - duty_active ← duty only on cycles where pwm_cnt = DUTY_MAX, so there is no mid-period glitch.
  - light ← (pwm_cnt < duty_active), registered.
  - duty 0 gives light constantly 0; DUTY_MAX gives light high DUTY_MAX of every 2^DUTY_W cycles.
- Simultaneous events:
  - rst beats everything.
  - en=0 beats a tick in RISE/HOLD_HI: go to FALL, no duty increment.
  - freeze=1 does not block en-driven transitions.

Decomposition:
- Shared include/package `breath_defs`: phase state encodings (ST_IDLE..ST_HOLD_LO, 3-bit) and DUTY_W default; used by the FSM and the bench.
- Sub-module `pwm_gen`: contains pwm_cnt, the duty_active latch and the light register.
  - Ports: clk, rst, duty, light.
- The FSM, prescaler and hold counter stay in breath_sequencer.

Test Plan:
1. Reset: rst=1 for 3 cycles with en=1, speed=2 → light=0, duty=0, phase=0, cycle_done=0; en stays high after release → phase=1 one edge later.
2. Rise (PRESCALE=4, HOLD_STEPS=2, speed=0, en=1) → duty increments every 4 cycles; phase=2 exactly 1020 cycles after RISE entry, with duty=255.
3. Full cycle (same configuration) → cycle_done pulses once, width 1, 2056 cycles after RISE entry (514 ticks); phase returns to 1 and duty=0.
4. Fade-out: drop en when duty=100 in RISE → phase=3 next edge, duty 100 unchanged. Duty reaches 0 after 100 ticks, then phase=0 with no cycle_done.
5. PWM duty: freeze=1 at duty=64 → light high exactly 64 of every 256 cycles; prescaler and duty static for 300 cycles. Release freeze → ticks resume.
6. Speed and reset:
   - speed=3 → tick every 32 cycles.
   - Switch to speed=0 mid-count → tick within ≤4 cycles.
   - Assert rst during FALL at duty=50 → next edge phase=0, duty=0, light=0.
